// File: rtl/mat_vec_mul_serial_pkg.sv
// Shared fixed-point types and FSM encodings for the serial matrix-vector unit.
// Holds default word format, saturation bounds and rounding constant.
package mat_vec_mul_serial_pkg;

    localparam int FXP_N    = 16;
    localparam int FXP_FRAC = 8;

    // N-bit saturation bounds and half-LSB rounding constant
    localparam logic signed [FXP_N-1:0] FXP_MAX =
        {1'b0, {(FXP_N-1){1'b1}}};
    localparam logic signed [FXP_N-1:0] FXP_MIN =
        {1'b1, {(FXP_N-1){1'b0}}};
    localparam logic signed [FXP_N-1:0] FXP_HALF =
        FXP_N'(1) << (FXP_FRAC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // counter width that never collapses to zero bits
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_vec_mul_serial_round.sv
// fxp_round_sat: combinational ACC_W -> N reduction (round, >>FRAC, sat/wrap).
// Ports: acc_i wide sum in, z_o N-bit result, ovf_o value out of N-bit range.
module fxp_round_sat #(
    parameter int N     = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 34,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [N-1:0]     z_o,
    output logic                    ovf_o
);

    localparam int HSH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic signed [ACC_W-1:0] HALF =
        (ROUND != 0 && FRAC > 0) ? (ACC_W'(1) << HSH) : '0;
    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shf;
    logic                    hi;
    logic                    lo;

    always_comb begin
        rnd   = acc_i + HALF;
        // arithmetic shift gives floor, so +HALF is round-half-up
        shf   = rnd >>> FRAC;
        hi    = shf > MAXV;
        lo    = shf < MINV;
        ovf_o = hi | lo;
        if (SAT != 0 && hi) begin
            z_o = MAXV[N-1:0];
        end else if (SAT != 0 && lo) begin
            z_o = MINV[N-1:0];
        end else begin
            z_o = shf[N-1:0];
        end
    end

endmodule

// File: rtl/mat_vec_mul_serial.sv
// Serial Z = H*x (+b) unit, one MAC per clock, start/done one-shot protocol.
// Ports: clk, rst_n, start, add_b, H, x, b in; done, busy, ovf, Z out.
module mat_vec_mul_serial
    import mat_vec_mul_serial_pkg::*;
#(
    parameter int N     = FXP_N,
    parameter int FRAC  = FXP_FRAC,
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   add_b,
    input  logic [ROWS*COLS*N-1:0] H,
    input  logic [COLS*N-1:0]      x,
    input  logic [ROWS*N-1:0]      b,
    output logic                   done,
    output logic                   busy,
    output logic                   ovf,
    output logic [ROWS*N-1:0]      Z
);

    localparam int ACC_W = 2*N + $clog2(COLS) + 1;
    localparam int RW    = cnt_w(ROWS);
    localparam int CW    = cnt_w(COLS);

    logic [1:0]              state_q;
    logic [RW-1:0]           r_q;
    logic [CW-1:0]           c_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [ROWS*COLS*N-1:0]  h_q;
    logic [COLS*N-1:0]       x_q;
    logic [ROWS*N-1:0]       b_q;
    logic                    addb_q;
    logic [ROWS*N-1:0]       buf_q;
    logic [ROWS*N-1:0]       buf_d;
    logic [ROWS*N-1:0]       z_q;
    logic                    ovf_q;
    logic                    ovfacc_q;

    logic signed [N-1:0]     h_el;
    logic signed [N-1:0]     x_el;
    logic signed [N-1:0]     b_el;
    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] bias;
    logic signed [ACC_W-1:0] rs_in;
    logic [N-1:0]            row_z;
    logic                    row_ovf;
    logic                    last_c;
    logic                    last_r;
    logic                    accept;

    // a new request is also taken on the edge that ends the done cycle
    assign accept = start &&
        (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_c = (c_q == CW'(COLS - 1));
    assign last_r = (r_q == RW'(ROWS - 1));

    always_comb begin
        h_el  = h_q[(int'(r_q)*COLS + int'(c_q))*N +: N];
        x_el  = x_q[int'(c_q)*N +: N];
        b_el  = b_q[int'(r_q)*N +: N];
        prod  = h_el * x_el;
        sum   = acc_q + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
        bias  = '0;
        if (addb_q) begin
            bias = {{(ACC_W-N){b_el[N-1]}}, b_el} <<< FRAC;
        end
        rs_in = sum + bias;
        buf_d = buf_q;
        if (state_q == ST_MAC && last_c) begin
            buf_d[int'(r_q)*N +: N] = row_z;
        end
    end

    fxp_round_sat #(
        .N     (N),
        .FRAC  (FRAC),
        .ACC_W (ACC_W),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_rs (
        .acc_i (rs_in),
        .z_o   (row_z),
        .ovf_o (row_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            h_q      <= '0;
            x_q      <= '0;
            b_q      <= '0;
            addb_q   <= 1'b0;
            buf_q    <= '0;
            z_q      <= '0;
            ovf_q    <= 1'b0;
            ovfacc_q <= 1'b0;
        end else if (accept) begin
            state_q  <= ST_MAC;
            r_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            h_q      <= H;
            x_q      <= x;
            b_q      <= b;
            addb_q   <= add_b;
            ovfacc_q <= 1'b0;
        end else begin
            case (state_q)
                ST_MAC: begin
                    if (last_c) begin
                        acc_q    <= '0;
                        c_q      <= '0;
                        buf_q    <= buf_d;
                        ovfacc_q <= ovfacc_q | row_ovf;
                        if (last_r) begin
                            // publish all rows at once, final row included
                            z_q     <= buf_d;
                            ovf_q   <= ovfacc_q | row_ovf;
                            state_q <= ST_DONE;
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end else begin
                        acc_q <= sum;
                        c_q   <= c_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done = (state_q == ST_DONE);
    assign busy = (state_q != ST_IDLE);
    assign ovf  = ovf_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_mat_vec_mul_serial.sv
// Directed bench for mat_vec_mul_serial: several geometries and modes.
// Q8.8 words, S = 256; expected values are hand-computed constants.
module tb_mat_vec_mul_serial;

    logic clk;
    logic rst_n;

    // 2x2, ROUND=1, SAT=1
    logic        st_a, ab_a, done_a, busy_a, ovf_a;
    logic [63:0] H_a;
    logic [31:0] x_a, b_a, Z_a;
    // 3x2 with bias
    logic        st_b, ab_b, done_b, busy_b, ovf_b;
    logic [95:0] H_b;
    logic [31:0] x_b;
    logic [47:0] b_b, Z_b;
    // 1x2, SAT=1 and SAT=0 on shared inputs
    logic        st_s, ab_s;
    logic        done_s1, busy_s1, ovf_s1;
    logic        done_s0, busy_s0, ovf_s0;
    logic [31:0] H_s, x_s;
    logic [15:0] b_s, Z_s1, Z_s0;
    // 1x1, ROUND=1 and ROUND=0 on shared inputs
    logic        st_r, ab_r;
    logic        done_r1, busy_r1, ovf_r1;
    logic        done_r0, busy_r0, ovf_r0;
    logic [15:0] H_r, x_r, b_r, Z_r1, Z_r0;

    int n_cmp = 0;
    int n_bad = 0;
    int first, pulses;
    logic bok;

    mat_vec_mul_serial #(.N(16), .FRAC(8), .ROWS(2), .COLS(2))
    u22 (.clk(clk), .rst_n(rst_n), .start(st_a), .add_b(ab_a),
         .H(H_a), .x(x_a), .b(b_a), .done(done_a), .busy(busy_a),
         .ovf(ovf_a), .Z(Z_a));

    mat_vec_mul_serial #(.N(16), .FRAC(8), .ROWS(3), .COLS(2))
    u32 (.clk(clk), .rst_n(rst_n), .start(st_b), .add_b(ab_b),
         .H(H_b), .x(x_b), .b(b_b), .done(done_b), .busy(busy_b),
         .ovf(ovf_b), .Z(Z_b));

    mat_vec_mul_serial #(.N(16), .FRAC(8), .ROWS(1), .COLS(2),
                         .SAT(1))
    us1 (.clk(clk), .rst_n(rst_n), .start(st_s), .add_b(ab_s),
         .H(H_s), .x(x_s), .b(b_s), .done(done_s1), .busy(busy_s1),
         .ovf(ovf_s1), .Z(Z_s1));

    mat_vec_mul_serial #(.N(16), .FRAC(8), .ROWS(1), .COLS(2),
                         .SAT(0))
    us0 (.clk(clk), .rst_n(rst_n), .start(st_s), .add_b(ab_s),
         .H(H_s), .x(x_s), .b(b_s), .done(done_s0), .busy(busy_s0),
         .ovf(ovf_s0), .Z(Z_s0));

    mat_vec_mul_serial #(.N(16), .FRAC(8), .ROWS(1), .COLS(1),
                         .ROUND(1))
    ur1 (.clk(clk), .rst_n(rst_n), .start(st_r), .add_b(ab_r),
         .H(H_r), .x(x_r), .b(b_r), .done(done_r1), .busy(busy_r1),
         .ovf(ovf_r1), .Z(Z_r1));

    mat_vec_mul_serial #(.N(16), .FRAC(8), .ROWS(1), .COLS(1),
                         .ROUND(0))
    ur0 (.clk(clk), .rst_n(rst_n), .start(st_r), .add_b(ab_r),
         .H(H_r), .x(x_r), .b(b_r), .done(done_r0), .busy(busy_r0),
         .ovf(ovf_r0), .Z(Z_r0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic dn(input int w);
        case (w)
            0: return done_a;
            1: return done_b;
            2: return done_s1;
            default: return done_r1;
        endcase
    endfunction

    function automatic logic bz(input int w);
        case (w)
            0: return busy_a;
            1: return busy_b;
            2: return busy_s1;
            default: return busy_r1;
        endcase
    endfunction

    // watch a bounded number of edges; report first done edge,
    // number of done cycles, and whether busy held up to done
    task automatic wait_done(input int w, input int budget,
                             output int f, output int p,
                             output logic ok);
        f = 0;
        p = 0;
        ok = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (f == 0 && !bz(w)) ok = 1'b0;
            if (dn(w)) begin
                p++;
                if (f == 0) f = k;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        st_a = 0; ab_a = 0; H_a = '0; x_a = '0; b_a = '0;
        st_b = 0; ab_b = 0; H_b = '0; x_b = '0; b_b = '0;
        st_s = 0; ab_s = 0; H_s = '0; x_s = '0; b_s = '0;
        st_r = 0; ab_r = 0; H_r = '0; x_r = '0; b_r = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_Z", 64'(Z_a), 64'h0);
        chk("rst_done", 64'(done_a), 64'h0);
        chk("rst_busy", 64'(busy_a), 64'h0);
        chk("rst_ovf", 64'(ovf_a), 64'h0);

        // 2x2 identity, x = [1.5, -0.75]
        @(negedge clk);
        H_a = {16'h0100, 16'h0000, 16'h0000, 16'h0100};
        x_a = {16'hFF40, 16'h0180};
        st_a = 1'b1;
        @(posedge clk);
        #1 st_a = 1'b0;
        chk("id_busy_e0", 64'(busy_a), 64'h1);
        wait_done(0, 8, first, pulses, bok);
        chk("id_lat", 64'(first), 64'd4);
        chk("id_pulses", 64'(pulses), 64'd1);
        chk("id_busy_hold", 64'(bok), 64'h1);
        chk("id_Z", 64'(Z_a), 64'hFF40_0180);
        chk("id_ovf", 64'(ovf_a), 64'h0);
        chk("id_busy_end", 64'(busy_a), 64'h0);

        // 3x2 with bias
        @(negedge clk);
        H_b = {16'h0080, 16'h0080, 16'h0000,
               16'hFF00, 16'h0200, 16'h0100};
        x_b = {16'h0100, 16'h0100};
        b_b = {16'h0000, 16'h0100, 16'h0000};
        ab_b = 1'b1;
        st_b = 1'b1;
        @(posedge clk);
        #1 st_b = 1'b0;
        H_b = '0;
        x_b = '0;
        ab_b = 1'b0;
        wait_done(1, 9, first, pulses, bok);
        chk("b32_lat", 64'(first), 64'd6);
        chk("b32_Z", 64'(Z_b), 64'h0100_0000_0300);
        chk("b32_ovf", 64'(ovf_b), 64'h0);

        // 1x2 saturate vs wrap, all-max operands
        @(negedge clk);
        H_s = {16'h7FFF, 16'h7FFF};
        x_s = {16'h7FFF, 16'h7FFF};
        st_s = 1'b1;
        @(posedge clk);
        #1 st_s = 1'b0;
        wait_done(2, 4, first, pulses, bok);
        chk("sat_lat", 64'(first), 64'd2);
        chk("sat1_Z", 64'(Z_s1), 64'h7FFF);
        chk("sat1_ovf", 64'(ovf_s1), 64'h1);
        chk("sat0_Z", 64'(Z_s0), 64'hFE00);
        chk("sat0_ovf", 64'(ovf_s0), 64'h1);

        // 1x1 rounding, +0.5 LSB
        @(negedge clk);
        H_r = 16'h0001;
        x_r = 16'h0080;
        st_r = 1'b1;
        @(posedge clk);
        #1 st_r = 1'b0;
        wait_done(3, 3, first, pulses, bok);
        chk("rnd_lat", 64'(first), 64'd1);
        chk("rnd1_pos", 64'(Z_r1), 64'h0001);
        chk("rnd0_pos", 64'(Z_r0), 64'h0000);

        // 1x1 rounding, -0.5 LSB
        @(negedge clk);
        x_r = 16'hFF80;
        st_r = 1'b1;
        @(posedge clk);
        #1 st_r = 1'b0;
        wait_done(3, 3, first, pulses, bok);
        chk("rnd1_neg", 64'(Z_r1), 64'h0000);
        chk("rnd0_neg", 64'(Z_r0), 64'hFFFF);

        // start re-pulsed at E2 must be ignored
        @(negedge clk);
        H_a = {16'h0100, 16'h0000, 16'h0100, 16'h0100};
        x_a = {16'h0200, 16'h0100};
        st_a = 1'b1;
        @(posedge clk);
        #1 st_a = 1'b0;
        @(posedge clk);
        #1;
        H_a = '0;
        x_a = '0;
        st_a = 1'b1;
        @(posedge clk);
        #1 st_a = 1'b0;
        wait_done(0, 2, first, pulses, bok);
        chk("rep_lat", 64'(first), 64'd2);
        chk("rep_Z", 64'(Z_a), 64'h0200_0300);
        @(posedge clk);
        #1;
        chk("rep_done_fall", 64'(done_a), 64'h0);
        chk("rep_busy_fall", 64'(busy_a), 64'h0);

        // start in the cycle after done falls is accepted
        H_a = {16'h0100, 16'h0000, 16'h0000, 16'h0100};
        x_a = {16'hFF40, 16'h0180};
        st_a = 1'b1;
        @(posedge clk);
        #1 st_a = 1'b0;
        chk("nxt_busy", 64'(busy_a), 64'h1);
        wait_done(0, 6, first, pulses, bok);
        chk("nxt_lat", 64'(first), 64'd4);
        chk("nxt_pulses", 64'(pulses), 64'd1);
        chk("nxt_Z", 64'(Z_a), 64'hFF40_0180);

        // asynchronous reset at E2 of a 2x2 op
        @(negedge clk);
        H_a = {16'h0100, 16'h0000, 16'h0100, 16'h0100};
        x_a = {16'h0200, 16'h0100};
        st_a = 1'b1;
        @(posedge clk);
        #1 st_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_Z", 64'(Z_a), 64'h0);
        chk("ar_done", 64'(done_a), 64'h0);
        chk("ar_busy", 64'(busy_a), 64'h0);
        chk("ar_ovf_s1", 64'(ovf_s1), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(0, 6, first, pulses, bok);
        chk("ar_no_done", 64'(pulses), 64'd0);
        chk("ar_Z_hold", 64'(Z_a), 64'h0);

        // fresh start after reset
        @(negedge clk);
        st_a = 1'b1;
        @(posedge clk);
        #1 st_a = 1'b0;
        wait_done(0, 6, first, pulses, bok);
        chk("post_lat", 64'(first), 64'd4);
        chk("post_Z", 64'(Z_a), 64'h0200_0300);
        chk("post_ovf", 64'(ovf_a), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
